// File: rtl/control_unit_if.sv
// Control-unit bus: instruction ROM port plus the datapath control and monitor signals.
// The control unit takes the master side; ROM/datapath/monitors take the slave side.
interface control_unit_if #(
    parameter int PC_W = 7
);
    logic [15:0]     instr_data;
    logic [PC_W-1:0] pc_addr;
    logic [15:0]     ir_out;
    logic [3:0]      state_out;
    logic            halted;
    logic [7:0]      D_addr;
    logic            D_wr;
    logic            RF_sel;
    logic            RF_W_en;
    logic [2:0]      ALU_s0;
    logic [3:0]      rdAddrA;
    logic [3:0]      rdAddrB;
    logic [3:0]      WriteAddr;

    modport master (
        input  instr_data,
        output pc_addr, ir_out, state_out, halted, D_addr, D_wr,
               RF_sel, RF_W_en, ALU_s0, rdAddrA, rdAddrB, WriteAddr
    );

    modport slave (
        output instr_data,
        input  pc_addr, ir_out, state_out, halted, D_addr, D_wr,
               RF_sel, RF_W_en, ALU_s0, rdAddrA, rdAddrB, WriteAddr
    );
endinterface

// File: rtl/control_unit.sv
// Instruction-sequencing FSM: owns PC and IR, fetches from a 1-cycle ROM and
// drives datapath controls as a Moore decode of the registered state and IR.
module control_unit #(
    parameter int PC_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    control_unit_if.master   bus
);

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_STORE  = 4'd4,
        ST_LOAD_A = 4'd5,
        ST_LOAD_B = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [PC_W-1:0] pc_r;
    logic [15:0]     ir_r;

    logic [7:0]      d_addr_s;
    logic            d_wr_s;
    logic            rf_sel_s;
    logic            rf_w_en_s;
    logic [2:0]      alu_s0_s;
    logic            halted_s;

    // State, PC and IR registers; IR load and PC increment happen only in FETCH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_INIT;
            pc_r    <= {PC_W{1'b0}};
            ir_r    <= 16'h0000;
        end else begin
            state_r <= state_s;
            if (state_r == ST_FETCH) begin
                ir_r <= bus.instr_data;
                pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
            end else begin
                ir_r <= ir_r;
                pc_r <= pc_r;
            end
        end
    end

    // Next-state selection; HALT is absorbing until reset
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_INIT:   state_s = ST_FETCH;
            ST_FETCH:  state_s = ST_DECODE;
            ST_DECODE: begin
                case (ir_r[15:12])
                    4'h1:    state_s = ST_STORE;
                    4'h2:    state_s = ST_LOAD_A;
                    4'h3:    state_s = ST_ADD;
                    4'h4:    state_s = ST_SUB;
                    4'h5:    state_s = ST_HALT;
                    default: state_s = ST_NOOP;
                endcase
            end
            ST_NOOP:   state_s = ST_FETCH;
            ST_STORE:  state_s = ST_FETCH;
            ST_LOAD_A: state_s = ST_LOAD_B;
            ST_LOAD_B: state_s = ST_FETCH;
            ST_ADD:    state_s = ST_FETCH;
            ST_SUB:    state_s = ST_FETCH;
            ST_HALT:   state_s = ST_HALT;
            default:   state_s = ST_INIT;
        endcase
    end

    // Moore control decode; LOAD_A only presents the address while memory read settles
    always_comb begin
        d_addr_s  = 8'h00;
        d_wr_s    = 1'b0;
        rf_sel_s  = 1'b0;
        rf_w_en_s = 1'b0;
        alu_s0_s  = 3'b000;
        halted_s  = 1'b0;
        case (state_r)
            ST_STORE: begin
                d_wr_s   = 1'b1;
                d_addr_s = ir_r[7:0];
            end
            ST_LOAD_A: begin
                rf_sel_s = 1'b1;
                d_addr_s = ir_r[11:4];
            end
            ST_LOAD_B: begin
                rf_sel_s  = 1'b1;
                rf_w_en_s = 1'b1;
                d_addr_s  = ir_r[11:4];
            end
            ST_ADD: begin
                alu_s0_s  = 3'b001;
                rf_w_en_s = 1'b1;
            end
            ST_SUB: begin
                alu_s0_s  = 3'b010;
                rf_w_en_s = 1'b1;
            end
            ST_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                d_addr_s = 8'h00;
            end
        endcase
    end

    assign bus.pc_addr   = pc_r;
    assign bus.ir_out    = ir_r;
    assign bus.state_out = state_r;
    assign bus.halted    = halted_s;
    assign bus.D_addr    = d_addr_s;
    assign bus.D_wr      = d_wr_s;
    assign bus.RF_sel    = rf_sel_s;
    assign bus.RF_W_en   = rf_w_en_s;
    assign bus.ALU_s0    = alu_s0_s;
    assign bus.rdAddrA   = ir_r[11:8];
    assign bus.rdAddrB   = ir_r[7:4];
    assign bus.WriteAddr = ir_r[3:0];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a program-level model pushes the expected
// per-cycle control word into a queue, which is popped and compared every cycle.
module tb_control_unit;

    localparam int PC_W = 3;

    localparam logic [3:0] S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                           S_NOOP = 4'd3, S_STORE = 4'd4, S_LOAD_A = 4'd5,
                           S_LOAD_B = 4'd6, S_ADD = 4'd7, S_SUB = 4'd8,
                           S_HALT = 4'd9;

    typedef struct packed {
        logic [3:0]  st;
        logic [2:0]  pc;
        logic [15:0] ir;
        logic        halted;
        logic [7:0]  daddr;
        logic        dwr;
        logic        rfsel;
        logic        rfwen;
        logic [2:0]  alu;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  w;
    } rec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [15:0] rom [8];
    rec_t exp_q [$];
    rec_t obs_q [$];
    int checks = 0;
    int errors = 0;

    control_unit_if #(.PC_W(PC_W)) cif ();

    control_unit #(.PC_W(PC_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (cif)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency
    always_ff @(posedge clk) cif.instr_data <= rom[cif.pc_addr];

    function automatic rec_t mk(input logic [3:0] st, input logic [2:0] pc, input logic [15:0] ir);
        rec_t r;
        r = '0;
        r.st = st; r.pc = pc; r.ir = ir;
        r.a = ir[11:8]; r.b = ir[7:4]; r.w = ir[3:0];
        case (st)
            S_STORE:  begin r.dwr = 1'b1; r.daddr = ir[7:0]; end
            S_LOAD_A: begin r.rfsel = 1'b1; r.daddr = ir[11:4]; end
            S_LOAD_B: begin r.rfsel = 1'b1; r.rfwen = 1'b1; r.daddr = ir[11:4]; end
            S_ADD:    begin r.alu = 3'b001; r.rfwen = 1'b1; end
            S_SUB:    begin r.alu = 3'b010; r.rfwen = 1'b1; end
            S_HALT:   r.halted = 1'b1;
            default:  r.halted = 1'b0;
        endcase
        return r;
    endfunction

    function automatic rec_t observe();
        rec_t r;
        r.st = cif.state_out; r.pc = cif.pc_addr; r.ir = cif.ir_out;
        r.halted = cif.halted; r.daddr = cif.D_addr; r.dwr = cif.D_wr;
        r.rfsel = cif.RF_sel; r.rfwen = cif.RF_W_en; r.alu = cif.ALU_s0;
        r.a = cif.rdAddrA; r.b = cif.rdAddrB; r.w = cif.WriteAddr;
        return r;
    endfunction

    // Expand the ROM program into the expected cycle-by-cycle control words
    task automatic build_expect(input int n);
        logic [2:0]  pc;
        logic [15:0] ir;
        pc = 3'd0;
        ir = 16'h0000;
        exp_q.delete();
        exp_q.push_back(mk(S_INIT, pc, ir));
        while (exp_q.size() < n) begin
            exp_q.push_back(mk(S_FETCH, pc, ir));
            ir = rom[pc];
            pc = pc + 3'd1;
            exp_q.push_back(mk(S_DECODE, pc, ir));
            case (ir[15:12])
                4'h1: exp_q.push_back(mk(S_STORE, pc, ir));
                4'h2: begin
                    exp_q.push_back(mk(S_LOAD_A, pc, ir));
                    exp_q.push_back(mk(S_LOAD_B, pc, ir));
                end
                4'h3: exp_q.push_back(mk(S_ADD, pc, ir));
                4'h4: exp_q.push_back(mk(S_SUB, pc, ir));
                4'h5: while (exp_q.size() < n) exp_q.push_back(mk(S_HALT, pc, ir));
                default: exp_q.push_back(mk(S_NOOP, pc, ir));
            endcase
        end
        while (exp_q.size() > n) void'(exp_q.pop_back());
    endtask

    task automatic start();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Pop one expected word per cycle (sampled on the falling edge) and compare
    task automatic run_sb(input int n, input string tag);
        rec_t e, o;
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            o = observe();
            obs_q.push_back(o);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s_underflow cycle %0d got %h required queued entry", tag, i, o);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s_cycle%0d got %h required %h", tag, i, o, e);
                end
            end
        end
    endtask

    task automatic load_demo();
        rom[0] = 16'h2011; rom[1] = 16'h2022; rom[2] = 16'h3123; rom[3] = 16'h4210;
        rom[4] = 16'h5000; rom[5] = 16'h0000; rom[6] = 16'h0000; rom[7] = 16'h0000;
    endtask

    task automatic test_reset();
        rec_t o;
        load_demo();
        build_expect(12);
        start();
        run_sb(12, "reset_pre");
        checks++;
        if (obs_q[11].alu !== 3'b001) begin
            errors++;
            $display("FAIL reset_in_add got alu %b required 001", obs_q[11].alu);
        end
        #1 reset_n = 1'b0;
        #1 o = observe();
        checks++;
        if (o !== rec_t'('0)) begin
            errors++;
            $display("FAIL reset_async got %h required %h", o, rec_t'('0));
        end
        @(posedge clk);
        #1 o = observe();
        checks++;
        if (o !== rec_t'('0)) begin
            errors++;
            $display("FAIL reset_hold got %h required %h", o, rec_t'('0));
        end
        build_expect(3);
        @(negedge clk);
        reset_n = 1'b1;
        run_sb(3, "reset_release");
    endtask

    task automatic test_program();
        int first_halt;
        load_demo();
        build_expect(40);
        start();
        run_sb(40, "prog");
        first_halt = -1;
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i].halted === 1'b1 && first_halt < 0) first_halt = i;
        checks++;
        if (first_halt != 17) begin
            errors++;
            $display("FAIL prog_halt_cycle got %0d required 17", first_halt);
        end
    endtask

    task automatic test_store();
        int n_wr;
        for (int i = 0; i < 8; i++) rom[i] = 16'h5000;
        rom[0] = 16'h116A;
        build_expect(10);
        start();
        run_sb(10, "store");
        n_wr = 0;
        foreach (obs_q[i]) if (obs_q[i].dwr === 1'b1) n_wr++;
        checks++;
        if (n_wr != 1) begin
            errors++;
            $display("FAIL store_dwr_count got %0d required 1", n_wr);
        end
    endtask

    task automatic test_noop();
        for (int i = 0; i < 8; i++) rom[i] = 16'h5000;
        rom[0] = 16'h7000;
        rom[1] = 16'h0000;
        build_expect(10);
        start();
        run_sb(10, "noop");
        checks++;
        if (obs_q[7].st !== S_FETCH || obs_q[7].pc !== 3'd2) begin
            errors++;
            $display("FAIL noop_pc got st %0d pc %0d required st 1 pc 2", obs_q[7].st, obs_q[7].pc);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
        rom[7] = 16'h6ABC;
        build_expect(30);
        start();
        run_sb(30, "wrap");
        checks++;
        if (obs_q[25].st !== S_FETCH || obs_q[25].pc !== 3'd0) begin
            errors++;
            $display("FAIL wrap_pc got st %0d pc %0d required st 1 pc 0", obs_q[25].st, obs_q[25].pc);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            rom[i] = {4'($urandom_range(0, 4)), 12'($urandom)};
        rom[6] = 16'h4F0E;
        rom[7] = {4'($urandom_range(6, 15)), 12'($urandom)};
        build_expect(60);
        start();
        run_sb(60, "b2b");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
        test_reset();
        test_program();
        test_store();
        test_noop();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
